// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : load-use stall and taken-branch flush control for a 5-stage
//               MIPS pipeline. Optional counters under HAZARD_PERF_EN.
// Revision    : 1.0
// ============================================================================
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] IFID_rs,
  input  logic [REG_W-1:0] IFID_rt,
  input  logic             IFID_branch,
  input  logic             IDEX_memRead,
  input  logic [REG_W-1:0] IDEX_rt,
  input  logic             branchTaken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEX_bubble,
  output logic             flushIFID,
  output logic             flushEXMEM,
  output logic             PCSrc,
  output logic             spurious,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  logic       load_use;
  logic       flush;
  logic       stall;
  logic [1:0] br_pipe_q, br_pipe_d;   // [0]=branch in EX, [1]=branch in MEM
  logic       spurious_q, spurious_d;

  always_comb begin
    load_use = IDEX_memRead && (IDEX_rt != '0) &&
               ((IDEX_rt == IFID_rs) || (IDEX_rt == IFID_rt));
    flush    = br_pipe_q[1] & branchTaken;
    // A taken branch squashes the stalled instruction anyway, so flush wins.
    stall    = load_use & ~flush;

    if (flush)
      br_pipe_d = 2'b00;
    else if (stall)
      br_pipe_d = {br_pipe_q[0], 1'b0};
    else
      br_pipe_d = {br_pipe_q[0], IFID_branch};

    spurious_d = spurious_q | (branchTaken & ~br_pipe_q[1]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      br_pipe_q  <= 2'b00;
      spurious_q <= 1'b0;
    end else begin
      br_pipe_q  <= br_pipe_d;
      spurious_q <= spurious_d;
    end
  end

  assign PCWrite     = ~stall;
  assign IFIDWrite   = ~stall;
  assign IDEX_bubble = stall | flush;
  assign flushIFID   = flush;
  assign flushEXMEM  = flush;
  assign PCSrc       = flush;
  assign spurious    = spurious_q;

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != c_CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != c_CNT_MAX))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;
`else
  assign stallCount = '0;
  assign flushCount = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl : vector table, directed corner sequences and random
//                  stimulus against a queue-based reference model.
// Revision       : 1.0
// ============================================================================
module tb_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [REG_W-1:0] IFID_rs = '0, IFID_rt = '0, IDEX_rt = '0;
  logic             IFID_branch = 1'b0, IDEX_memRead = 1'b0, branchTaken = 1'b0;
  logic             PCWrite, IFIDWrite, IDEX_bubble, flushIFID, flushEXMEM, PCSrc, spurious;
  logic [CNT_W-1:0] stallCount, flushCount;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_branch(IFID_branch),
    .IDEX_memRead(IDEX_memRead), .IDEX_rt(IDEX_rt), .branchTaken(branchTaken),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEX_bubble(IDEX_bubble),
    .flushIFID(flushIFID), .flushEXMEM(flushEXMEM), .PCSrc(PCSrc),
    .spurious(spurious), .stallCount(stallCount), .flushCount(flushCount)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: branches in flight as a queue, index 0 = EX, index 1 = MEM.
  bit shadow[$];
  bit m_spur;
  int m_sc, m_fc;
  bit m_stall, m_flush;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    shadow.delete();
    shadow.push_back(1'b0);
    shadow.push_back(1'b0);
    m_spur = 0;
    m_sc = 0;
    m_fc = 0;
  endtask

  // Drive one cycle of inputs and check the outputs against the model.
  task automatic apply(input bit rst, input bit br, input bit bt, input bit mr,
                       input bit [4:0] ex_rt, input bit [4:0] rs, input bit [4:0] rt);
    bit lu;
    reset = rst; IFID_branch = br; branchTaken = bt; IDEX_memRead = mr;
    IDEX_rt = ex_rt; IFID_rs = rs; IFID_rt = rt;
    #2;
    lu      = mr && (ex_rt != 0) && (ex_rt == rs || ex_rt == rt);
    m_flush = shadow[1] && bt;
    m_stall = lu && !m_flush;
    chk("pcwrite",    32'(PCWrite),     32'(!m_stall));
    chk("ifidwrite",  32'(IFIDWrite),   32'(!m_stall));
    chk("bubble",     32'(IDEX_bubble), 32'(m_stall || m_flush));
    chk("flushifid",  32'(flushIFID),   32'(m_flush));
    chk("flushexmem", 32'(flushEXMEM),  32'(m_flush));
    chk("pcsrc",      32'(PCSrc),       32'(m_flush));
    chk("spurious",   32'(spurious),    32'(m_spur));
`ifdef HAZARD_PERF_EN
    chk("stallcount", 32'(stallCount),  32'(m_sc));
    chk("flushcount", 32'(flushCount),  32'(m_fc));
`else
    chk("stallcount", 32'(stallCount),  32'd0);
    chk("flushcount", 32'(flushCount),  32'd0);
`endif
  endtask

  // Clock edge: update the model from the inputs held in the current cycle.
  task automatic advance();
    int cmax;
    cmax = (1 << CNT_W) - 1;
    if (reset) begin
      model_reset();
    end else begin
      if (branchTaken && !shadow[1]) m_spur = 1;
      if (m_stall && m_sc < cmax) m_sc++;
      if (m_flush && m_fc < cmax) m_fc++;
      void'(shadow.pop_back());
      if (m_flush) begin
        shadow.delete();
        shadow.push_back(1'b0);
        shadow.push_back(1'b0);
      end else begin
        shadow.push_front(m_stall ? 1'b0 : IFID_branch);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(); apply(0, 0, 0, 0, 0, 0, 0); advance(); endtask

  typedef struct {
    bit       mr;
    bit [4:0] ex_rt;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       exp_stall;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1, 5'd8,  5'd8,  5'd3,  1};  // match on rs
    vecs[1] = '{1, 5'd9,  5'd2,  5'd9,  1};  // match on rt
    vecs[2] = '{1, 5'd0,  5'd0,  5'd0,  0};  // $zero exempt
    vecs[3] = '{0, 5'd8,  5'd8,  5'd8,  0};  // not a load
    vecs[4] = '{1, 5'd7,  5'd6,  5'd5,  0};  // no match
    vecs[5] = '{1, 5'd31, 5'd31, 5'd31, 1};  // both match, top reg
    vecs[6] = '{1, 5'd1,  5'd0,  5'd1,  1};
    vecs[7] = '{1, 5'd16, 5'd0,  5'd17, 0};

    // Initial reset
    @(posedge clock); #1;
    model_reset();
    apply(1, 0, 0, 0, 0, 0, 0);
    advance();

    // Reset state with quiet inputs
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("reset_pcwrite", 32'(PCWrite), 32'd1);
    chk("reset_spurious", 32'(spurious), 32'd0);
    advance();

    // Table of single-cycle load-use vectors
    foreach (vecs[i]) begin
      apply(0, 0, 0, vecs[i].mr, vecs[i].ex_rt, vecs[i].rs, vecs[i].rt);
      chk("vec_pcwrite", 32'(PCWrite), 32'(!vecs[i].exp_stall));
      chk("vec_bubble",  32'(IDEX_bubble), 32'(vecs[i].exp_stall));
      advance();
    end

    // Load-use on rs: stall exactly one cycle, then nop in EX
    apply(0, 0, 0, 1, 8, 8, 0);
    chk("lu_stall", 32'(PCWrite), 32'd0);
    advance();
    apply(0, 0, 0, 0, 8, 8, 0);
    chk("lu_release", 32'(PCWrite), 32'd1);
    advance();

    // Taken branch: ID at N, flush at N+2 only
    apply(0, 1, 0, 0, 0, 0, 0); advance();
    apply(0, 0, 0, 0, 0, 0, 0); advance();
    apply(0, 0, 1, 0, 0, 0, 0);
    chk("taken_pcsrc", 32'(PCSrc), 32'd1);
    chk("taken_flushexmem", 32'(flushEXMEM), 32'd1);
    advance();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("taken_after", 32'(PCSrc), 32'd0);
    advance();

    // Not-taken branch
    apply(0, 1, 0, 0, 0, 0, 0); advance();
    apply(0, 0, 0, 0, 0, 0, 0); advance();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("nottaken_flush", 32'(flushIFID), 32'd0);
    advance();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("nottaken_spur", 32'(spurious), 32'd0);
    advance();

    // Flush beats stall
    apply(0, 1, 0, 0, 0, 0, 0); advance();
    apply(0, 0, 0, 0, 0, 0, 0); advance();
    apply(0, 0, 1, 1, 4, 4, 0);
    chk("prio_pcwrite", 32'(PCWrite), 32'd1);
    chk("prio_pcsrc", 32'(PCSrc), 32'd1);
    chk("prio_bubble", 32'(IDEX_bubble), 32'd1);
    advance();
    idle();

    // Branch squashed by a stall is not tracked: the later taken is spurious
    apply(0, 1, 0, 1, 3, 3, 0); advance();
    apply(0, 0, 0, 0, 0, 0, 0); advance();
    apply(0, 0, 1, 0, 0, 0, 0);
    chk("squash_noflush", 32'(PCSrc), 32'd0);
    advance();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("squash_spur", 32'(spurious), 32'd1);
    advance();

    // Reset clears spurious; next-cycle branchTaken does not flush
    apply(1, 0, 0, 0, 0, 0, 0); advance();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("rst_spur_clear", 32'(spurious), 32'd0);
    advance();

    // Spurious sticky
    apply(0, 0, 1, 0, 0, 0, 0);
    chk("spur_noflush", 32'(flushIFID), 32'd0);
    advance();
    idle();
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("spur_sticky", 32'(spurious), 32'd1);
    advance();

    // Branch then reset mid-flight: no flush follows
    apply(0, 1, 0, 0, 0, 0, 0); advance();
    apply(1, 0, 0, 0, 0, 0, 0); advance();
    apply(0, 0, 1, 0, 0, 0, 0);
    chk("midrst_noflush", 32'(PCSrc), 32'd0);
    advance();

    // Random stimulus
    for (int n = 0; n < 3000; n++) begin
      apply(($urandom_range(0, 60) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)));
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
